// File: rtl/pointer_ctrl_if.sv
// Stone-placement handshake between pointer_ctrl and the game logic.
// place_req stays high with place_x/place_y stable until place_ack is sampled.
interface pointer_ctrl_if #(
  parameter int XW = 4,
  parameter int YW = 4
);
  logic          place_req;
  logic          place_ack;
  logic [XW-1:0] place_x;
  logic [YW-1:0] place_y;

  modport master (
    output place_req,
    output place_x,
    output place_y,
    input  place_ack
  );

  modport slave (
    input  place_req,
    input  place_x,
    input  place_y,
    output place_ack
  );
endinterface

// File: rtl/pointer_ctrl.sv
// Key debounce, wrapping cursor movement and placement request FSM
// feeding the game-logic block and the display redraw path.
module pointer_ctrl #(
  parameter int BOARD_W      = 15,
  parameter int BOARD_H      = 15,
  parameter int XW           = 4,
  parameter int YW           = 4,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic           Clck,
  input  logic           Reset,
  input  logic           key_up,
  input  logic           key_down,
  input  logic           key_left,
  input  logic           key_right,
  input  logic           key_place,
  input  logic           game_over,
  pointer_ctrl_if.master place,
  output logic [XW-1:0]  pointer_loc_x,
  output logic [YW-1:0]  pointer_loc_y,
  output logic           redraw_req
);

  localparam int CW = $clog2(DEBOUNCE_CYC);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [XW-1:0] X_MAX   = XW'(BOARD_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(BOARD_H - 1);
  localparam logic [XW-1:0] X_RST   = XW'((BOARD_W - 1) / 2);
  localparam logic [YW-1:0] Y_RST   = YW'((BOARD_H - 1) / 2);

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_PLACE = 4;

  typedef enum logic {
    IDLE,
    REQ
  } state_e;

  logic [4:0]         raw;
  logic [4:0]         s1_q;
  logic [4:0]         s2_q;
  logic [4:0]         deb_q;
  logic [4:0]         deb_d;
  logic [4:0]         debr_q;
  logic [4:0]         press;
  logic [4:0][CW-1:0] cnt_q;
  logic [4:0][CW-1:0] cnt_d;

  state_e             state_q;
  state_e             state_d;

  logic               mv_any;
  logic               mv_en;
  logic               cap;
  logic               req;

  logic [XW-1:0]      x_q;
  logic [XW-1:0]      x_d;
  logic [YW-1:0]      y_q;
  logic [YW-1:0]      y_d;
  logic [XW-1:0]      px_q;
  logic [XW-1:0]      px_d;
  logic [YW-1:0]      py_q;
  logic [YW-1:0]      py_d;
  logic               redraw_q;
  logic               redraw_d;

  assign raw = {key_place, key_right, key_left, key_down, key_up};

  // A lane only flips once sync has disagreed for DEBOUNCE_CYC edges in a row.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int k = 0; k < 5; k++) begin
      if (s2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          deb_d[k] = s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      debr_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      debr_q <= deb_q;
      cnt_q  <= cnt_d;
    end
  end

  assign press  = deb_q & ~debr_q;
  assign mv_any = |press[K_RIGHT:K_UP];

  always_ff @(posedge Clck) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!game_over && press[K_PLACE] && !mv_any) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (place.place_ack || game_over) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mv_en = (state_q == IDLE) && !game_over;
    cap   = (state_q == IDLE) && (state_d == REQ);
    req   = (state_q == REQ);
  end

  // Opposite presses on one axis cancel; the axes move independently.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (mv_en) begin
      unique case (1'b1)
        press[K_RIGHT] && !press[K_LEFT]:
          x_d = (x_q == X_MAX) ? '0 : x_q + 1'b1;
        press[K_LEFT] && !press[K_RIGHT]:
          x_d = (x_q == '0) ? X_MAX : x_q - 1'b1;
        default:
          x_d = x_q;
      endcase
      unique case (1'b1)
        press[K_DOWN] && !press[K_UP]:
          y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
        press[K_UP] && !press[K_DOWN]:
          y_d = (y_q == '0) ? Y_MAX : y_q - 1'b1;
        default:
          y_d = y_q;
      endcase
    end
  end

  always_comb begin
    px_d     = cap ? x_q : px_q;
    py_d     = cap ? y_q : py_q;
    redraw_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      x_q      <= X_RST;
      y_q      <= Y_RST;
      px_q     <= '0;
      py_q     <= '0;
      redraw_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      px_q     <= px_d;
      py_q     <= py_d;
      redraw_q <= redraw_d;
    end
  end

  assign pointer_loc_x   = x_q;
  assign pointer_loc_y   = y_q;
  assign redraw_req      = redraw_q;
  assign place.place_req = req;
  assign place.place_x   = px_q;
  assign place.place_y   = py_q;

endmodule
